// File: rtl/regex_pc_buffer.sv
// regex_pc_buffer: deduplicating thread-PC FIFO between seed/CPU-feedback writers and the CPU fetch port,
// with per-context occupancy and global idle reporting.
module regex_pc_buffer #(
  parameter int PC_WIDTH              = 9,
  parameter int CC_ID_BITS            = 2,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_seed_valid,
  input  logic [PC_WIDTH-1:0]        i_seed_pc,
  input  logic [CC_ID_BITS-1:0]      i_seed_cc_id,
  output logic                       o_seed_ready,
  input  logic                       i_in_pc_valid,
  input  logic [PC_WIDTH-1:0]        i_in_pc,
  input  logic [CC_ID_BITS-1:0]      i_in_cc_id,
  output logic                       o_in_pc_ready,
  output logic                       o_out_pc_valid,
  output logic [PC_WIDTH-1:0]        o_out_pc,
  output logic [CC_ID_BITS-1:0]      o_out_cc_id,
  input  logic                       i_out_pc_ready,
  input  logic                       i_cpu_running,
  output logic [(1<<CC_ID_BITS)-1:0] o_cc_pending,
  output logic                       o_dup_drop,
  output logic                       o_idle
);
  localparam int AW    = FIFO_WIDTH_POWER_OF_2;
  localparam int CW    = FIFO_WIDTH_POWER_OF_2 + 1;
  localparam int DEPTH = 1 << FIFO_WIDTH_POWER_OF_2;
  localparam int NCC   = 1 << CC_ID_BITS;

  logic [PC_WIDTH-1:0]   r_pc [DEPTH];
  logic [CC_ID_BITS-1:0] r_cc [DEPTH];
  logic [DEPTH-1:0]      r_v;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_dup_drop;
  logic [DEPTH-1:0]      w_match;
  logic [PC_WIDTH-1:0]   w_pc;
  logic [CC_ID_BITS-1:0] w_cc;
  logic                  w_full, w_empty, w_fire, w_hit, w_store, w_pop;

  assign w_full         = r_count == CW'(DEPTH);
  assign w_empty        = r_count == '0;
  assign o_in_pc_ready  = !w_full;
  assign o_seed_ready   = !w_full && !i_in_pc_valid;
  // CPU feedback always wins the shared write port so the CPU never stalls behind a seed
  assign w_pc           = i_in_pc_valid ? i_in_pc : i_seed_pc;
  assign w_cc           = i_in_pc_valid ? i_in_cc_id : i_seed_cc_id;
  assign w_fire         = !w_full && (i_in_pc_valid || i_seed_valid);
  assign w_hit          = |w_match;
  assign w_store        = w_fire && !w_hit;
  assign w_pop          = !w_empty && i_out_pc_ready;
  assign o_out_pc_valid = !w_empty;
  assign o_out_pc       = r_pc[r_rd_ptr];
  assign o_out_cc_id    = r_cc[r_rd_ptr];
  assign o_dup_drop     = r_dup_drop;
  assign o_idle         = w_empty && !i_cpu_running && !i_seed_valid;

  // An entry popped on this edge is still valid here, so a same-edge rewrite is dropped
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    assign w_match[k] = r_v[k] && r_pc[k] == w_pc && r_cc[k] == w_cc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_v        <= '0;
      r_dup_drop <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k] <= '0;
        r_cc[k] <= '0;
      end
    end else begin
      r_dup_drop <= w_fire && w_hit;
      r_count    <= r_count + CW'(w_store) - CW'(w_pop);
      if (w_store) begin
        r_pc[r_wr_ptr] <= w_pc;
        r_cc[r_wr_ptr] <= w_cc;
        r_v[r_wr_ptr]  <= 1'b1;
        r_wr_ptr       <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_v[r_rd_ptr] <= 1'b0;
        r_rd_ptr      <= r_rd_ptr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCC; i++) begin : g_pend
    logic [CW-1:0] r_pend;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_pend <= '0;
      else r_pend <= r_pend + CW'(w_store && w_cc == CC_ID_BITS'(i))
                            - CW'(w_pop && r_cc[r_rd_ptr] == CC_ID_BITS'(i));
    end
    assign o_cc_pending[i] = |r_pend;
  end
endmodule

// File: tb/tb_regex_pc_buffer.sv
// tb_regex_pc_buffer: table vectors, directed corner sequences and random traffic against a queue model.
module tb_regex_pc_buffer;
  typedef struct packed {logic [8:0] pc; logic [1:0] cc;} ent_t;
  typedef struct {
    logic iv; logic [8:0] ipc; logic [1:0] icc;
    logic sv; logic [8:0] spc; logic [1:0] scc; logic ordy;
    logic ev; logic [8:0] epc; logic [1:0] ecc; logic [3:0] epend; logic edup;
  } vec_t;

  logic       clk, rst_n;
  logic       seed_valid, seed_ready, in_pc_valid, in_pc_ready;
  logic [8:0] seed_pc, in_pc, out_pc;
  logic [1:0] seed_cc_id, in_cc_id, out_cc_id;
  logic       out_pc_valid, out_pc_ready, cpu_running, dup_drop, idle;
  logic [3:0] cc_pending;

  int   n_cmp = 0, n_fail = 0;
  ent_t q[$];
  ent_t dut_pops[$];
  vec_t tbl[16];

  regex_pc_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_seed_valid(seed_valid), .i_seed_pc(seed_pc), .i_seed_cc_id(seed_cc_id), .o_seed_ready(seed_ready),
    .i_in_pc_valid(in_pc_valid), .i_in_pc(in_pc), .i_in_cc_id(in_cc_id), .o_in_pc_ready(in_pc_ready),
    .o_out_pc_valid(out_pc_valid), .o_out_pc(out_pc), .o_out_cc_id(out_cc_id), .i_out_pc_ready(out_pc_ready),
    .i_cpu_running(cpu_running), .o_cc_pending(cc_pending), .o_dup_drop(dup_drop), .o_idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_pend();
    logic [3:0] p = '0;
    foreach (q[k]) p[q[k].cc] = 1'b1;
    return p;
  endfunction

  // One clock of stimulus; the model is a plain queue of queued {pc, cc} pairs
  task automatic cyc(input logic iv, input logic [8:0] ipc, input logic [1:0] icc, input logic sv,
                     input logic [8:0] spc, input logic [1:0] scc, input logic ordy, input logic run);
    ent_t w;
    bit   full, hit, fire;
    in_pc_valid = iv; in_pc = ipc; in_cc_id = icc;
    seed_valid = sv; seed_pc = spc; seed_cc_id = scc;
    out_pc_ready = ordy; cpu_running = run;
    #1;
    full = q.size() == 4;
    chk("in_pc_ready", in_pc_ready, !full);
    chk("seed_ready", seed_ready, !full && !iv);
    chk("idle", idle, q.size() == 0 && !run && !sv);
    if (out_pc_valid && ordy) dut_pops.push_back('{out_pc, out_cc_id});
    w    = iv ? '{ipc, icc} : '{spc, scc};
    fire = !full && (iv || sv);
    hit  = 0;
    foreach (q[k]) if (q[k] == w) hit = 1;
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (fire && !hit) q.push_back(w);
    @(posedge clk); #1;
    chk("out_pc_valid", out_pc_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_cc_id", out_cc_id, q[0].cc);
    end
    chk("cc_pending", cc_pending, exp_pend());
    chk("dup_drop", dup_drop, fire && hit);
  endtask

  initial begin
    tbl[0]  = '{1, 9'h100, 1, 0, 0, 0, 0, 1, 9'h100, 1, 4'b0010, 0};
    tbl[1]  = '{1, 9'h100, 1, 0, 0, 0, 0, 1, 9'h100, 1, 4'b0010, 1};
    tbl[2]  = '{1, 9'h100, 2, 0, 0, 0, 0, 1, 9'h100, 1, 4'b0110, 0};
    tbl[3]  = '{0, 9'h000, 0, 0, 0, 0, 1, 1, 9'h100, 2, 4'b0100, 0};
    tbl[4]  = '{0, 9'h000, 0, 0, 0, 0, 1, 0, 9'h000, 0, 4'b0000, 0};
    tbl[5]  = '{1, 9'h010, 0, 0, 0, 0, 0, 1, 9'h010, 0, 4'b0001, 0};
    tbl[6]  = '{0, 9'h000, 0, 1, 9'h020, 3, 0, 1, 9'h010, 0, 4'b1001, 0};
    tbl[7]  = '{0, 9'h000, 0, 1, 9'h021, 3, 0, 1, 9'h010, 0, 4'b1001, 0};
    tbl[8]  = '{0, 9'h000, 0, 0, 0, 0, 1, 1, 9'h020, 3, 4'b1000, 0};
    tbl[9]  = '{0, 9'h000, 0, 0, 0, 0, 1, 1, 9'h021, 3, 4'b1000, 0};
    tbl[10] = '{0, 9'h000, 0, 0, 0, 0, 1, 0, 9'h000, 0, 4'b0000, 0};
    tbl[11] = '{1, 9'h0F5, 0, 0, 0, 0, 0, 1, 9'h0F5, 0, 4'b0001, 0};
    tbl[12] = '{1, 9'h0F5, 0, 0, 0, 0, 1, 0, 9'h000, 0, 4'b0000, 1};
    tbl[13] = '{1, 9'h0F5, 0, 0, 0, 0, 0, 1, 9'h0F5, 0, 4'b0001, 0};
    tbl[14] = '{1, 9'h0F6, 0, 0, 0, 0, 1, 1, 9'h0F6, 0, 4'b0001, 0};
    tbl[15] = '{0, 9'h000, 0, 0, 0, 0, 1, 0, 9'h000, 0, 4'b0000, 0};

    rst_n = 0; seed_valid = 0; seed_pc = 0; seed_cc_id = 0; in_pc_valid = 0; in_pc = 0; in_cc_id = 0;
    out_pc_ready = 0; cpu_running = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_pc_valid", out_pc_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_cc_id", out_cc_id, 0);
    chk("rst_cc_pending", cc_pending, 0);
    chk("rst_dup_drop", dup_drop, 0);
    chk("rst_in_pc_ready", in_pc_ready, 1);
    chk("rst_seed_ready", seed_ready, 1);
    chk("rst_idle", idle, 1);
    in_pc_valid = 1; #1;
    chk("rst_seed_ready_cpu", seed_ready, 0);
    in_pc_valid = 0;
    rst_n = 1;

    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 9'(9'h011 + k), 2'(k), 0, 1);
    seed_valid = 0; cpu_running = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_pc_valid", out_pc_valid, 0);
    chk("midrst_cc_pending", cc_pending, 0);
    chk("midrst_in_pc_ready", in_pc_ready, 1);
    chk("midrst_idle", idle, 1);
    q.delete();
    @(posedge clk); #1 rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    dut_pops.delete();
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 9'(245 + k), 2, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("wrap_count", dut_pops.size(), 8);
    foreach (dut_pops[k]) begin
      chk($sformatf("wrap_pc%0d", k), dut_pops[k].pc, 245 + k);
      chk($sformatf("wrap_cc%0d", k), dut_pops[k].cc, 2);
    end

    dut_pops.delete();
    for (int k = 0; k < 4; k++) cyc(1, 9'(9'h1A0 + k), 1, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 9'h1B0, 1, 1, 9'h1C0, 0, 0, 1);
    cyc(1, 9'h1B0, 1, 1, 9'h1C0, 0, 1, 1);
    cyc(1, 9'h1B0, 1, 1, 9'h1C0, 0, 0, 1);
    cyc(1, 9'h1B0, 1, 1, 9'h1C0, 0, 1, 1);
    cyc(0, 0, 0, 1, 9'h1C0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("prio_count", dut_pops.size(), 6);
    if (dut_pops.size() == 6) begin
      chk("prio_pop4", dut_pops[4].pc, 9'h1B0);
      chk("prio_pop5", dut_pops[5].pc, 9'h1C0);
      chk("prio_pop3", dut_pops[3].pc, 9'h1A3);
    end

    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].ipc, tbl[i].icc, tbl[i].sv, tbl[i].spc, tbl[i].scc, tbl[i].ordy, 0);
      chk($sformatf("vec%0d_valid", i), out_pc_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("vec%0d_cc", i), out_cc_id, tbl[i].ecc);
      end
      chk($sformatf("vec%0d_pend", i), cc_pending, tbl[i].epend);
      chk($sformatf("vec%0d_dup", i), dup_drop, tbl[i].edup);
    end

    for (int n = 0; n < 600; n++)
      cyc(1'($urandom % 3 == 0), 9'($urandom_range(0, 5)), 2'($urandom), 1'($urandom),
          9'($urandom_range(0, 5)), 2'($urandom), 1'($urandom % 3 != 0), 1'($urandom));
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
